// File: rtl/sprite_pos_ctrl.sv
// Pushbutton-driven sprite position controller: sync + debounce four keys, step
// the (x, y) position with auto-repeat, clamp to the visible area.

// state | meaning
// IDLE  | no sole key of the pair pressed; waiting
// MOVE  | apply one +/-1 step (with clamp), arm the repeat timer
// HOLD  | latched key still sole-pressed; count down to the next step
module sprite_axis_fsm #(
    parameter int POS_W       = 10,
    parameter int STEP_CYCLES = 500000,
    parameter int POS_MAX     = 635,
    parameter int POS_INIT    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_center,
    input  logic             i_inc_key,
    input  logic             i_dec_key,
    output logic [POS_W-1:0] o_pos,
    output logic             o_blocked,
    output logic             o_busy
);
    localparam int TMR_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES - 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 2);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [POS_W-1:0] P_MAX    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_INIT   = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] P_ONE    = POS_W'(1);

    typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

    state_t           state, state_nxt;
    logic             dir_inc, dir_inc_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic             inc_sole, dec_sole, latched_sole;

    assign inc_sole     = i_inc_key & ~i_dec_key;
    assign dec_sole     = i_dec_key & ~i_inc_key;
    assign latched_sole = dir_inc ? inc_sole : dec_sole;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            dir_inc <= 1'b0;
            tmr     <= '0;
            pos     <= P_INIT;
        end else begin
            state   <= state_nxt;
            dir_inc <= dir_inc_nxt;
            tmr     <= tmr_nxt;
            pos     <= pos_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dir_inc_nxt = dir_inc;
        tmr_nxt     = tmr;
        pos_nxt     = pos;
        o_blocked   = 1'b0;
        if (i_center) begin
            state_nxt = IDLE;
            pos_nxt   = P_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (inc_sole || dec_sole) begin
                        state_nxt   = MOVE;
                        dir_inc_nxt = inc_sole;
                    end
                end
                MOVE: begin
                    state_nxt = HOLD;
                    tmr_nxt   = TMR_LOAD;
                    // Compare before add/sub so the position can never wrap.
                    if (dir_inc) begin
                        if (pos == P_MAX) o_blocked = 1'b1;
                        else              pos_nxt   = pos + P_ONE;
                    end else begin
                        if (pos == '0) o_blocked = 1'b1;
                        else           pos_nxt   = pos - P_ONE;
                    end
                end
                HOLD: begin
                    if (!latched_sole)   state_nxt = IDLE;
                    else if (tmr == '0)  state_nxt = MOVE;
                    else                 tmr_nxt   = tmr - TMR_ONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign o_pos  = pos;
    assign o_busy = (state != IDLE);
endmodule

module sprite_pos_ctrl #(
    parameter int POS_W       = 10,
    parameter int DEB_CYCLES  = 250000,
    parameter int STEP_CYCLES = 500000,
    parameter int X_MAX       = 635,
    parameter int Y_MAX       = 475,
    parameter int X_INIT      = 0,
    parameter int Y_INIT      = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_up,
    input  logic             i_key_down,
    input  logic             i_key_left,
    input  logic             i_key_right,
    input  logic             i_center,
    output logic [POS_W-1:0] o_x_pos,
    output logic [POS_W-1:0] o_y_pos,
    output logic             o_edge_hit,
    output logic             o_moving
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    // Key index: 0 up, 1 down, 2 left, 3 right. All key vectors are active-low.
    logic [3:0]       key_raw, sync_1, sync_2, deb_state;
    logic [DEB_W-1:0] deb_cnt [4];
    logic [3:0]       pressed;
    logic             blk_x, blk_y, busy_x, busy_y;

    assign key_raw = {i_key_right, i_key_left, i_key_down, i_key_up};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1 <= 4'hF;
            sync_2 <= 4'hF;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_state <= 4'hF;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == deb_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_state[i] <= sync_2[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                end
            end
        end
    end

    assign pressed = ~deb_state;

    sprite_axis_fsm #(
        .POS_W(POS_W), .STEP_CYCLES(STEP_CYCLES), .POS_MAX(X_MAX), .POS_INIT(X_INIT)
    ) u_axis_x (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_center(i_center),
        .i_inc_key(pressed[3]), .i_dec_key(pressed[2]),
        .o_pos(o_x_pos), .o_blocked(blk_x), .o_busy(busy_x)
    );

    sprite_axis_fsm #(
        .POS_W(POS_W), .STEP_CYCLES(STEP_CYCLES), .POS_MAX(Y_MAX), .POS_INIT(Y_INIT)
    ) u_axis_y (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_center(i_center),
        .i_inc_key(pressed[0]), .i_dec_key(pressed[1]),
        .o_pos(o_y_pos), .o_blocked(blk_y), .o_busy(busy_y)
    );

    // Blocked flags are already suppressed by i_center inside the axis FSMs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_edge_hit <= 1'b0;
        else          o_edge_hit <= blk_x | blk_y;
    end

    assign o_moving = busy_x | busy_y;
endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Bench for sprite_pos_ctrl: directed key sequences, a phase-based reference
// model compared every cycle, plus hand-computed literal checkpoints.
module tb_sprite_pos_ctrl;
    localparam int POS_W = 10;
    localparam int DEB   = 4;
    localparam int STEP  = 8;
    localparam int XMAX  = 10;
    localparam int YMAX  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_up = 1'b1, key_down = 1'b1, key_left = 1'b1, key_right = 1'b1;
    logic center = 1'b0;
    logic [POS_W-1:0] x_pos, y_pos;
    logic edge_hit, moving;

    int n_checks = 0;
    int n_errors = 0;

    sprite_pos_ctrl #(
        .POS_W(POS_W), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP),
        .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(0), .Y_INIT(0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_up(key_up), .i_key_down(key_down),
        .i_key_left(key_left), .i_key_right(key_right),
        .i_center(center),
        .o_x_pos(x_pos), .o_y_pos(y_pos),
        .o_edge_hit(edge_hit), .o_moving(moving)
    );

    always #5 clk = ~clk;

    // Reference model: keys seen two cycles late, accepted after DEB differing
    // cycles; an engaged axis steps at phase 1, 1+STEP, ... and disengages on
    // any non-step cycle where its latched key is not the sole key pressed.
    logic [3:0] m_s1, m_s2, m_deb;
    int  m_run [4];
    int  m_pos [2];
    bit  m_eng [2];
    int  m_phase [2];
    bit  m_inc [2];
    bit  m_hit;

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        for (int a = 0; a < 2; a++) begin
            m_pos[a] = 0; m_eng[a] = 1'b0; m_phase[a] = 0; m_inc[a] = 1'b0;
        end
        m_hit = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        bit hit, inc, dec;
        int ii, di, mx;
        raw = {key_right, key_left, key_down, key_up};
        hit = 1'b0;
        for (int a = 0; a < 2; a++) begin
            ii = (a == 0) ? 3 : 0;
            di = (a == 0) ? 2 : 1;
            mx = (a == 0) ? XMAX : YMAX;
            inc = !m_deb[ii];
            dec = !m_deb[di];
            if (center) begin
                m_eng[a] = 1'b0;
                m_pos[a] = 0;
            end else if (!m_eng[a]) begin
                if (inc != dec) begin
                    m_eng[a] = 1'b1; m_phase[a] = 0; m_inc[a] = inc;
                end
            end else begin
                m_phase[a]++;
                if (m_phase[a] % STEP == 1) begin
                    if (m_inc[a]) begin
                        if (m_pos[a] >= mx) hit = 1'b1; else m_pos[a]++;
                    end else begin
                        if (m_pos[a] <= 0) hit = 1'b1; else m_pos[a]--;
                    end
                end else if (!(m_inc[a] ? (inc && !dec) : (dec && !inc))) begin
                    m_eng[a] = 1'b0;
                end
            end
        end
        m_hit = hit;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_deb[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_x_pos",    int'(x_pos),    m_pos[0]);
        check("model_y_pos",    int'(y_pos),    m_pos[1]);
        check("model_edge_hit", int'(edge_hit), int'(m_hit));
        check("model_moving",   int'(moving),   int'(m_eng[0] | m_eng[1]));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int hits, cnt;
        bit seen;
        model_reset();
        tick(3);
        rst_n = 1'b1;

        // 1: idle after reset
        tick(20);
        check("rst_x", int'(x_pos), 0);
        check("rst_y", int'(y_pos), 0);
        check("rst_hit", int'(edge_hit), 0);
        check("rst_moving", int'(moving), 0);

        // 2: 3-cycle glitch is rejected
        key_right = 1'b0;
        tick(3);
        key_right = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick(1);
            if (moving) seen = 1'b1;
        end
        check("glitch_moving", int'(seen), 0);
        check("glitch_x", int'(x_pos), 0);

        // 3: held key, first step after DEB+4 then every STEP
        key_right = 1'b0;
        tick(7);
        check("hold_x_c7", int'(x_pos), 0);
        tick(1);
        check("hold_x_c8", int'(x_pos), 1);
        tick(8);
        check("hold_x_c16", int'(x_pos), 2);
        tick(8);
        check("hold_x_c24", int'(x_pos), 3);
        key_right = 1'b1;
        cnt = 0;
        while (moving && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check("release_in_time", int'(cnt <= DEB + 3), 1);
        check("release_moving", int'(moving), 0);
        check("release_x", int'(x_pos), 3);

        center = 1'b1;
        tick(1);
        center = 1'b0;
        check("center_x", int'(x_pos), 0);
        tick(2);

        // 4: left at x=0 is blocked, one pulse per step
        key_left = 1'b0;
        hits = 0;
        repeat (26) begin
            tick(1);
            if (edge_hit) hits++;
        end
        check("left_hits", hits, 3);
        check("left_x", int'(x_pos), 0);
        key_left = 1'b1;
        tick(10);
        check("left_release_moving", int'(moving), 0);

        // 5: opposing keys together never move
        key_up = 1'b0;
        key_down = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick(1);
            if (moving) seen = 1'b1;
        end
        check("both_moving", int'(seen), 0);
        check("both_y", int'(y_pos), 0);
        key_up = 1'b1;
        key_down = 1'b1;
        tick(10);

        // 6: run to X_MAX, keep pressing, center mid-HOLD, async reset mid-HOLD
        key_right = 1'b0;
        tick(80);
        check("max_x", int'(x_pos), XMAX);
        hits = 0;
        repeat (20) begin
            tick(1);
            if (edge_hit) hits++;
        end
        check("max_hits", hits, 2);
        check("max_x_held", int'(x_pos), XMAX);
        center = 1'b1;
        tick(1);
        center = 1'b0;
        check("ctr_x_0", int'(x_pos), 0);
        tick(1);
        check("ctr_x_1", int'(x_pos), 0);
        check("ctr_moving", int'(moving), 1);
        tick(1);
        check("ctr_x_2", int'(x_pos), 1);
        tick(3);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_x", int'(x_pos), 0);
        check("arst_y", int'(y_pos), 0);
        check("arst_moving", int'(moving), 0);
        check("arst_hit", int'(edge_hit), 0);
        key_right = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);

        // 7: diagonal motion, both axes independent
        key_right = 1'b0;
        key_up = 1'b0;
        tick(16);
        check("diag_x", int'(x_pos), 2);
        check("diag_y", int'(y_pos), 2);
        key_right = 1'b1;
        key_up = 1'b1;
        tick(12);
        check("end_moving", int'(moving), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
